// File: rtl/decoder_with_hold.sv
// Binary-to-one-hot decoder with a valid/ready input, a fixed-width output pulse of HOLD cycles
// and a forced idle gap of GAP cycles before the next code can be taken.
module decoder_with_hold #(
    parameter int unsigned N_IN = 4,
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [N_IN-1:0]        binary_in_i,
    output logic [(1<<N_IN)-1:0]   decoder_out_o,
    output logic                   out_valid_o,
    output logic                   busy_o,
    output logic [7:0]             done_count_o
);

    localparam int unsigned W        = 1 << N_IN;
    localparam logic [7:0]  HoldLoad = 8'(HOLD - 1);
    localparam logic [7:0]  GapLoad  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [W-1:0]   out_q, out_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic [7:0]     done_q, done_d;
    logic [W-1:0]   onehot;

    assign onehot     = {{(W-1){1'b0}}, 1'b1} << binary_in_i;
    assign in_ready_o = (state_q == StIdle) && enable_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        // Dropping enable abandons whatever is in flight, including a pulse on its last cycle.
        if (!enable_i) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            out_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        state_d = StDrive;
                        cnt_d   = HoldLoad;
                        out_d   = onehot;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                StDrive: begin
                    if (cnt_q == 8'd0) begin
                        out_d   = '0;
                        valid_d = 1'b0;
                        done_d  = done_q + 8'd1;
                        if (GAP == 0) begin
                            state_d = StIdle;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = StGap;
                            cnt_d   = GapLoad;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StGap: begin
                    if (cnt_q == 8'd0) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    out_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            out_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign decoder_out_o = out_q;
    assign out_valid_o   = valid_q;
    assign busy_o        = busy_q;
    assign done_count_o  = done_q;

endmodule
